// File: rtl/decode_stage.sv
// Decode stage: splits the instruction word into fields, tracks pending register
// writes in a busy scoreboard and stalls on RAW/WAW hazards; HALT freezes issue until reset.
module decode_stage #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [BITS_DATA-1:0] in_instr,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_op,
  output logic [BITS_ADDR-1:0] out_rd,
  output logic [BITS_ADDR-1:0] out_rs1,
  output logic [BITS_ADDR-1:0] out_rs2,
  output logic                 out_we,
  output logic [BITS_DATA-1:0] out_imm,
  input  logic                 wb_valid,
  input  logic [BITS_ADDR-1:0] wb_addr,
  output logic                 halted,
  output logic                 illegal,
  output logic [15:0]          stall_cnt
);

  // state   | meaning
  // ST_RUN  | normal issue
  // ST_HALT | HALT accepted, no further issue until rst
  typedef enum logic {ST_RUN, ST_HALT} state_t;

  localparam int NUM_REGS = 1 << BITS_ADDR;
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_ADDI  = 6'h02;
  localparam logic [5:0] OP_STORE = 6'h03;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  state_t state_q, state_d;

  logic [5:0]           op;
  logic [BITS_ADDR-1:0] rd, rs1, rs2;
  logic [BITS_DATA-1:0] imm;
  logic                 legal, reads_rs1, reads_rs2, writes_rd;
  logic [NUM_REGS-1:0]  busy_q, busy_d, clr, busy_eff;
  logic                 hazard, accept;

  logic                 out_valid_q, out_valid_d;
  logic [5:0]           out_op_q, out_op_d;
  logic [BITS_ADDR-1:0] out_rd_q, out_rd_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic                 out_we_q, out_we_d;
  logic [BITS_DATA-1:0] out_imm_q, out_imm_d;
  logic                 illegal_q, illegal_d;
  logic [15:0]          stall_q, stall_d;

  assign op  = in_instr[31:26];
  assign rd  = in_instr[25:23];
  assign rs1 = in_instr[22:20];
  assign rs2 = in_instr[19:17];
  assign imm = {{(BITS_DATA-17){in_instr[16]}}, in_instr[16:0]};

  always_comb begin
    legal     = 1'b1;
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    case (op)
      OP_NOP:   ;
      OP_ADD:   begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; writes_rd = 1'b1; end
      OP_ADDI:  begin reads_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_STORE: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      OP_HALT:  ;
      default:  legal = 1'b0;
    endcase
  end

  // A writeback landing this cycle already resolves the hazard it would cause.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_REGS; i++)
      clr[i] = wb_valid && (wb_addr == BITS_ADDR'(i));
  end
  assign busy_eff = busy_q & ~clr;

  assign hazard = in_valid && ((reads_rs1 && busy_eff[rs1]) ||
                               (reads_rs2 && busy_eff[rs2]) ||
                               (writes_rd && busy_eff[rd]));
  assign halted   = (state_q == ST_HALT);
  assign in_ready = !halted && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && accept && op == OP_HALT)
      state_d = ST_HALT;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_rd_d    = out_rd_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_we_d    = out_we_q;
    out_imm_d   = out_imm_q;
    busy_d      = busy_eff;
    illegal_d   = accept && !legal;
    stall_d     = stall_q;
    if (accept && legal) begin
      out_valid_d = 1'b1;
      out_op_d    = op;
      out_rd_d    = rd;
      out_rs1_d   = rs1;
      out_rs2_d   = rs2;
      out_we_d    = writes_rd;
      out_imm_d   = imm;
      if (writes_rd)
        busy_d[rd] = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (in_valid && hazard && !halted && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_rd_q    <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_we_q    <= 1'b0;
      out_imm_q   <= '0;
      busy_q      <= '0;
      illegal_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_rd_q    <= out_rd_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_we_q    <= out_we_d;
      out_imm_q   <= out_imm_d;
      busy_q      <= busy_d;
      illegal_q   <= illegal_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_rd    = out_rd_q;
  assign out_rs1   = out_rs1_q;
  assign out_rs2   = out_rs2_q;
  assign out_we    = out_we_q;
  assign out_imm   = out_imm_q;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed expectations for issue, hazards,
// back-pressure, illegal opcodes, HALT and reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_we;
  logic [31:0] in_instr, out_imm;
  logic [5:0]  out_op;
  logic [2:0]  out_rd, out_rs1, out_rs2, wb_addr;
  logic        wb_valid, halted, illegal;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  decode_stage #(.BITS_DATA(32), .BITS_ADDR(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_we(out_we), .out_imm(out_imm),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .halted(halted), .illegal(illegal),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [16:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = '0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_halted",    32'(halted),    0);
    chk("rst_illegal",   32'(illegal),   0);
    chk("rst_stall",     32'(stall_cnt), 0);
    chk("rst_busy",      32'(dut.busy_q), 0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 1);

    // ADDI rd=1 rs1=0 imm=0x1FFFF
    in_valid = 1'b1; in_instr = mk(6'h02, 3'd1, 3'd0, 3'd0, 17'h1FFFF);
    #1 chk("addi_in_ready", 32'(in_ready), 1);
    step();
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_op",    32'(out_op),    32'h02);
    chk("addi_we",    32'(out_we),    1);
    chk("addi_rd",    32'(out_rd),    1);
    chk("addi_imm",   out_imm,        32'hFFFF_FFFF);
    chk("addi_busy",  32'(dut.busy_q), 32'h02);

    // ADD rd=2, then ADD rd=3 rs1=2 stalls until writeback of r2
    in_instr = mk(6'h01, 3'd2, 3'd0, 3'd0, 17'h0);
    step();
    chk("add_rd",   32'(out_rd),      2);
    chk("add_busy", 32'(dut.busy_q),  32'h06);
    in_instr = mk(6'h01, 3'd3, 3'd2, 3'd0, 17'h0);
    #1 chk("raw_in_ready", 32'(in_ready), 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("raw_stall", 32'(stall_cnt), 32'(i));
      chk("raw_hold",  32'(in_ready),  0);
    end
    chk("raw_drained", 32'(out_valid), 0);
    wb_valid = 1'b1; wb_addr = 3'd2;
    #1 chk("raw_wb_ready", 32'(in_ready), 1);
    step();
    wb_valid = 1'b0;
    chk("raw_acc_valid", 32'(out_valid),   1);
    chk("raw_acc_rs1",   32'(out_rs1),     2);
    chk("raw_acc_rd",    32'(out_rd),      3);
    chk("raw_acc_busy",  32'(dut.busy_q),  32'h0A);
    chk("raw_acc_stall", 32'(stall_cnt),   3);

    // illegal opcode 0x15
    in_instr = mk(6'h15, 3'd5, 3'd0, 3'd0, 17'h0);
    #1 chk("ill_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("ill_valid", 32'(out_valid),  0);
    chk("ill_pulse", 32'(illegal),    1);
    chk("ill_busy",  32'(dut.busy_q), 32'h0A);
    step();
    chk("ill_clear", 32'(illegal), 0);

    // writebacks: r1 clears, r5 (not busy) ignored, r3 clears
    wb_valid = 1'b1; wb_addr = 3'd1; step();
    chk("wb1_busy", 32'(dut.busy_q), 32'h08);
    wb_addr = 3'd5; step();
    chk("wb5_busy", 32'(dut.busy_q), 32'h08);
    wb_addr = 3'd3; step();
    chk("wb3_busy", 32'(dut.busy_q), 32'h00);
    wb_valid = 1'b0;

    // back-pressure
    in_valid = 1'b1; in_instr = mk(6'h02, 3'd4, 3'd0, 3'd0, 17'h00005);
    step();
    chk("bp_first_imm", out_imm, 32'h5);
    out_ready = 1'b0; in_instr = mk(6'h02, 3'd5, 3'd0, 3'd0, 17'h00007);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 0);
      step();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_rd",    32'(out_rd),    4);
      chk("bp_imm",   out_imm,        32'h5);
    end
    chk("bp_stall", 32'(stall_cnt), 3);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 1);
    step();
    chk("bp_next_rd",  32'(out_rd),     5);
    chk("bp_next_imm", out_imm,         32'h7);
    chk("bp_busy",     32'(dut.busy_q), 32'h30);

    // WAW on r4 resolved by same-cycle writeback; set must win over clear
    in_instr = mk(6'h02, 3'd4, 3'd0, 3'd0, 17'h10000);
    wb_valid = 1'b1; wb_addr = 3'd4;
    #1 chk("setwin_ready", 32'(in_ready), 1);
    step();
    wb_valid = 1'b0;
    chk("setwin_busy", 32'(dut.busy_q), 32'h30);
    chk("setwin_imm",  out_imm,         32'hFFFF_0000);

    // HALT
    in_instr = mk(6'h3F, 3'd0, 3'd0, 3'd0, 17'h0);
    step();
    chk("halt_op",     32'(out_op),    32'h3F);
    chk("halt_we",     32'(out_we),    0);
    chk("halt_valid",  32'(out_valid), 1);
    chk("halt_flag",   32'(halted),    1);
    in_instr = mk(6'h00, 3'd0, 3'd0, 3'd0, 17'h0);
    #1 chk("halt_ready", 32'(in_ready), 0);
    step();
    chk("halt_drain", 32'(out_valid), 0);
    in_instr = mk(6'h01, 3'd3, 3'd4, 3'd0, 17'h0);
    wb_valid = 1'b1; wb_addr = 3'd5;
    step();
    wb_valid = 1'b0;
    chk("halt_nostall", 32'(stall_cnt),  3);
    chk("halt_wb_busy", 32'(dut.busy_q), 32'h10);
    chk("halt_sticky",  32'(halted),     1);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("unhalt_flag",  32'(halted),   0);
    chk("unhalt_ready", 32'(in_ready), 1);

    // reset while output valid and busy=0x06
    in_valid = 1'b1; in_instr = mk(6'h01, 3'd1, 3'd0, 3'd0, 17'h0);
    step();
    in_instr = mk(6'h01, 3'd2, 3'd0, 3'd0, 17'h0);
    step();
    chk("pre_busy", 32'(dut.busy_q), 32'h06);
    out_ready = 1'b0; in_instr = mk(6'h01, 3'd3, 3'd1, 3'd0, 17'h1234);
    step();
    chk("pre_stall", 32'(stall_cnt), 1);
    chk("pre_valid", 32'(out_valid), 1);
    rst = 1'b1; wb_valid = 1'b1; wb_addr = 3'd1;
    step();
    chk("rst2_valid", 32'(out_valid),  0);
    chk("rst2_busy",  32'(dut.busy_q), 0);
    chk("rst2_stall", 32'(stall_cnt),  0);
    chk("rst2_op",    32'(out_op),     0);
    chk("rst2_rd",    32'(out_rd),     0);
    rst = 1'b0; wb_valid = 1'b0; in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
